interval_timer: RTL
===================

// Module: interval_timer
// PURPOSE
//  Countdown timer directly downstream of the time-parameter stage. The controller FSM
//  selects an interval and pulses Start_Timer. This block waits for the registered
//  duration 'value' to settle, latches it, and counts it down in whole seconds.
//  It returns a one-cycle 'expired' pulse to the controller.
//  It also generates the 1 Hz enable tick from the system clock.
// PARAMETERS
//  CLK_PER_SEC  100000000  system clock cycles per second (>=2); prescaler terminal count + 1
//  PRE_W        27         prescaler counter width; must hold CLK_PER_SEC-1
//  TVAL_W       4          width of duration 'value' and 'remaining' (seconds)
//  LOAD_DELAY   1          cycles from Start_Timer sample to 'value' sample (>=1); covers upstream register
// PORTS
//  clk            in   1       system clock, all logic on rising edge
//  Reset          in   1       synchronous, active-high reset
//  Start_Timer    in   1       level sampled each edge; high = (re)start an interval
//  value          in   TVAL_W  interval duration in seconds, valid LOAD_DELAY cycles after start
//  expired        out  1       registered one-cycle pulse: interval complete
//  busy           out  1       high in WAIT and COUNT
//  remaining      out  TVAL_W  seconds left while counting, else 0
//  one_hz_enable  out  1       one-cycle tick per CLK_PER_SEC clocks
// BEHAVIOUR
//  Reset (any state, takes priority over all inputs):
//   - state=IDLE; prescaler, wait counter, remaining and expired = 0; busy=0; one_hz_enable=0.
//   - Reset mid-interval aborts it; no expired pulse follows.
//  Prescaler:
//   - counts 0..CLK_PER_SEC-1 then wraps to 0.
//   - one_hz_enable high for the one cycle in which count == CLK_PER_SEC-1.
//   - cleared to 0 at the load edge (WAIT->COUNT), so each first second is full length.
//  FSM states: IDLE, WAIT, COUNT.
//   - IDLE:  Start_Timer=1 -> WAIT, wait counter=0.
//   - WAIT:  wait counter increments each edge.
//            At edge E0+LOAD_DELAY (E0 = start-sample edge), latch 'value' into remaining.
//            value!=0 -> COUNT; value==0 -> IDLE with expired=1 at that edge.
//   - COUNT: on each edge where one_hz_enable=1, remaining decrements by 1.
//            When the decrement reaches 0 -> IDLE, expired=1 at that same edge.
//  Latency:
//   - expired rises at edge E0 + LOAD_DELAY + value*CLK_PER_SEC and is high for exactly one cycle.
//   - remaining steps value, value-1, .. 1 every CLK_PER_SEC cycles, then 0.
//  Start_Timer=1 in WAIT or COUNT: restart.
//   - -> WAIT, wait counter=0; pending interval discarded; no expired for it.
//   - Applies even on the edge that would have completed the interval: restart wins, expired stays 0.
//  Start_Timer held high: restarts every edge; expired never asserts. The controller must pulse it.
//  'value' is ignored except at the load edge; changes during COUNT have no effect.
//  No wrap: remaining never decrements below 0; the width of 'value' bounds the interval (max 2^TVAL_W-1 s).
// TESTING (bench: CLK_PER_SEC=4, PRE_W=2, LOAD_DELAY=1)
//  1 Reset 3 cycles -> expired=0, busy=0, remaining=0, one_hz_enable=0.
//    Release -> one_hz_enable first high after edge 4, then every 4 cycles.
//  2 Start_Timer pulse sampled at edge 10, value=6 ->
//    busy from edge 10; remaining=6 at edge 11, then 5,4,3,2,1 at edges 15,19,23,27,31, then 0.
//    expired high for one cycle after edge 35; busy low.
//  3 Start pulse, value=0 -> expired high one cycle after edge E0+1; remaining stays 0; no COUNT entry.
//  4 Start value=6, re-pulse Start at remaining=3 with value=2 ->
//    no expired for the first interval; expired 1+2*4=9 edges after the restart edge.
//  5 Reset asserted while remaining=4 ->
//    all outputs 0 next cycle; no expired afterwards; a new start times correctly.
//  6 Start pulse coincident with the final-tick edge (remaining=1, one_hz_enable=1) ->
//    expired stays 0; new interval loads at the next edge.

Source files
------------

// File: rtl/interval_timer_if.sv
// Controller-facing bundle of the interval timer.
// Master is the controller FSM, slave is the timer.
interface interval_timer_if #(
    parameter int TVAL_W = 4
);
    logic              Start_Timer;
    logic [TVAL_W-1:0] value;
    logic              expired;
    logic              busy;
    logic [TVAL_W-1:0] remaining;
    logic              one_hz_enable;

    modport master (
        output Start_Timer,
        output value,
        input  expired,
        input  busy,
        input  remaining,
        input  one_hz_enable
    );

    modport slave (
        input  Start_Timer,
        input  value,
        output expired,
        output busy,
        output remaining,
        output one_hz_enable
    );
endinterface

// File: rtl/interval_timer.sv
// Whole-second countdown timer with a 1 Hz prescaler.
// Latches 'value' LOAD_DELAY cycles after start; pulses expired.
module interval_timer #(
    parameter int CLK_PER_SEC = 100000000,
    parameter int PRE_W       = 27,
    parameter int TVAL_W      = 4,
    parameter int LOAD_DELAY  = 1
) (
    input  logic             clk,
    input  logic             Reset,
    interval_timer_if.slave  tif
);
    localparam int WC_W = (LOAD_DELAY < 2) ? 1 : $clog2(LOAD_DELAY);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_SEC - 1);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(LOAD_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COUNT
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [PRE_W-1:0]  pre_q;
    logic [PRE_W-1:0]  pre_n;
    logic [WC_W-1:0]   wcnt_q;
    logic [WC_W-1:0]   wcnt_n;
    logic [TVAL_W-1:0] rem_q;
    logic [TVAL_W-1:0] rem_n;
    logic              exp_q;
    logic              exp_n;
    logic              tick;
    logic              start;

    assign tick  = (pre_q == PRE_MAX);
    assign start = tif.Start_Timer;

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt_q;
        rem_n   = rem_q;
        exp_n   = 1'b0;
        pre_n   = tick ? '0 : pre_q + 1'b1;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = WAIT;
                    wcnt_n  = '0;
                end
            end
            WAIT: begin
                if (start) begin
                    wcnt_n = '0;
                    rem_n  = '0;
                end else if (wcnt_q == WC_LAST) begin
                    rem_n = tif.value;
                    if (tif.value == '0) begin
                        state_n = IDLE;
                        exp_n   = 1'b1;
                    end else begin
                        // Restart the second so the first one is full length.
                        state_n = COUNT;
                        pre_n   = '0;
                    end
                end else begin
                    wcnt_n = wcnt_q + 1'b1;
                end
            end
            COUNT: begin
                if (start) begin
                    state_n = WAIT;
                    wcnt_n  = '0;
                    rem_n   = '0;
                end else if (tick) begin
                    if (rem_q <= TVAL_W'(1)) begin
                        state_n = IDLE;
                        rem_n   = '0;
                        exp_n   = 1'b1;
                    end else begin
                        rem_n = rem_q - 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                rem_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state  <= IDLE;
            pre_q  <= '0;
            wcnt_q <= '0;
            rem_q  <= '0;
            exp_q  <= 1'b0;
        end else begin
            state  <= state_n;
            pre_q  <= pre_n;
            wcnt_q <= wcnt_n;
            rem_q  <= rem_n;
            exp_q  <= exp_n;
        end
    end

    assign tif.expired       = exp_q;
    assign tif.busy          = (state != IDLE);
    assign tif.remaining     = rem_q;
    assign tif.one_hz_enable = tick;
endmodule
